mips16_hazard_sched: RTL and testbench

//  Issue scheduler / interlock controller for the 5-stage pipe_MIPS16 core (IF ID EX MEM WB).

---
 rtl/mips16_hazard_sched.sv | 140 ++++++++++++++
 tb/tb_mips16_hazard_sched.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips16_hazard_sched.sv
// RAW interlock, branch-flush and HLT-drain sequencer for the 5-stage MIPS16 pipe; outputs are
// combinational from registered EX/MEM/WB dest slots plus id_ir (zero latency); stall holds PC and IF/ID.
module mips16_hazard_sched #(
    parameter bit WB_BYPASS = 1'b1,
    parameter int CNT_W     = 16
) (
    input  logic             clk1,
    input  logic             reset,
    input  logic             id_valid,
    input  logic [15:0]      id_ir,
    input  logic             ex_taken_br,
    output logic             stall,
    output logic             bubble,
    output logic             flush,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cycles
);
    typedef enum logic [1:0] {S_RUN, S_DRAIN, S_HALT} state_t;

    typedef struct packed {
        logic       v;
        logic [2:0] rd;
    } slot_t;

    state_t     state_q, state_d;
    slot_t      ex_q, mem_q, wb_q, ex_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [3:0] op;
    logic [2:0] rs, rt, rd, dst;
    logic       rd_rs, rd_rt, dst_v, is_hlt, hazard;
    logic       unused_imm;

    assign op         = id_ir[15:12];
    assign rs         = id_ir[11:9];
    assign rt         = id_ir[8:6];
    assign rd         = id_ir[5:3];
    assign unused_imm = ^id_ir[2:0];
    assign is_hlt     = (op == 4'hF);

    always_comb begin
        rd_rs = 1'b0;
        rd_rt = 1'b0;
        dst_v = 1'b0;
        dst   = rt;
        case (op)
            4'h0, 4'h8, 4'h9, 4'hA: begin
                rd_rs = 1'b1;
                dst_v = 1'b1;
            end
            4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7: begin
                rd_rs = 1'b1;
                rd_rt = 1'b1;
                dst_v = 1'b1;
                dst   = rd;
            end
            4'hB: begin
                rd_rs = 1'b1;
                rd_rt = 1'b1;
            end
            4'hC, 4'hD: rd_rs = 1'b1;
            default: ;
        endcase
        // R0 is hardwired, so a write to it never needs tracking
        if (dst == 3'd0) dst_v = 1'b0;
    end

    function automatic logic src_hz(input logic [2:0] r, input slot_t e, input slot_t m,
                                    input slot_t w);
        logic h;
        h = (e.v && e.rd == r) || (m.v && m.rd == r) || (!WB_BYPASS && w.v && w.rd == r);
        return (r != 3'd0) && h;
    endfunction

    assign hazard = id_valid && ((rd_rs && src_hz(rs, ex_q, mem_q, wb_q)) ||
                                 (rd_rt && src_hz(rt, ex_q, mem_q, wb_q)));

    always_comb begin
        state_d = state_q;
        ex_d    = '0;
        cnt_d   = cnt_q;
        stall   = 1'b0;
        bubble  = 1'b0;
        flush   = 1'b0;
        halted  = 1'b0;
        if (reset) begin
            state_d = S_RUN;
            cnt_d   = '0;
        end else begin
            case (state_q)
                S_RUN: begin
                    if (ex_taken_br) begin
                        flush  = 1'b1;
                        bubble = 1'b1;
                    end else if (!id_valid) begin
                        bubble = 1'b1;
                    end else if (hazard) begin
                        stall  = 1'b1;
                        bubble = 1'b1;
                        cnt_d  = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
                    end else if (is_hlt) begin
                        state_d = S_DRAIN;
                    end else begin
                        ex_d = dst_v ? slot_t'{v: 1'b1, rd: dst} : '0;
                    end
                end
                S_DRAIN: begin
                    stall  = 1'b1;
                    bubble = 1'b1;
                    // EX is already empty here; once MEM is empty the edge leaves all three clear
                    if (!ex_q.v && !mem_q.v) state_d = S_HALT;
                end
                S_HALT: begin
                    halted = 1'b1;
                    stall  = 1'b1;
                    bubble = 1'b1;
                end
                default: state_d = S_RUN;
            endcase
        end
    end

    assign stall_cycles = reset ? '0 : cnt_q;

    always_ff @(posedge clk1) begin
        if (reset) begin
            state_q <= S_RUN;
            ex_q    <= '0;
            mem_q   <= '0;
            wb_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ex_q    <= ex_d;
            mem_q   <= ex_q;
            wb_q    <= mem_q;
            cnt_q   <= cnt_d;
        end
    end
endmodule

// File: tb/tb_mips16_hazard_sched.sv
// Two schedulers (WB bypass on / off, small counter on the second) driven in lockstep and scored
// against an issue-history reference model.
module tb_mips16_hazard_sched;
    logic clk1 = 1'b0;
    always #5 clk1 = ~clk1;

    logic        reset, id_valid, ex_taken_br;
    logic [15:0] id_ir;
    logic        stall1, bubble1, flush1, halted1;
    logic [15:0] cnt1;
    logic        stall0, bubble0, flush0, halted0;
    logic [3:0]  cnt0;

    mips16_hazard_sched #(.WB_BYPASS(1'b1), .CNT_W(16)) dut1 (
        .clk1(clk1), .reset(reset), .id_valid(id_valid), .id_ir(id_ir),
        .ex_taken_br(ex_taken_br), .stall(stall1), .bubble(bubble1), .flush(flush1),
        .halted(halted1), .stall_cycles(cnt1));

    mips16_hazard_sched #(.WB_BYPASS(1'b0), .CNT_W(4)) dut0 (
        .clk1(clk1), .reset(reset), .id_valid(id_valid), .id_ir(id_ir),
        .ex_taken_br(ex_taken_br), .stall(stall0), .bubble(bubble0), .flush(flush0),
        .halted(halted0), .stall_cycles(cnt0));

    typedef struct packed {
        logic        stall;
        logic        bubble;
        logic        flush;
        logic        halted;
        logic [15:0] cnt;
    } obs_t;

    obs_t q1[$];
    obs_t q0[$];
    int   checks = 0;
    int   passes = 0;
    int   cyc    = 0;

    // Model state, index 1 = bypass instance, 0 = no-bypass instance.
    // hist[k][d] = destination issued d+1 cycles ago (0 = nothing tracked).
    int hist[2][3];
    int mode[2];      // 0 run, 1 drain, 2 halt
    int halt_at[2];
    int last_dc[2];
    int cnt[2];
    int cmax[2];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic model(input int k, input bit rst, input bit v, input logic [15:0] ir,
                         input bit br, output obs_t e);
        int op, rs, rt, rd, dst, issued, depth;
        int srcs[$];
        bit hz;
        e      = '0;
        issued = 0;
        hz     = 0;
        dst    = 0;
        op     = int'(ir[15:12]);
        rs     = int'(ir[11:9]);
        rt     = int'(ir[8:6]);
        rd     = int'(ir[5:3]);
        if (rst) begin
            for (int d = 0; d < 3; d++) hist[k][d] = 0;
            mode[k]    = 0;
            cnt[k]     = 0;
            last_dc[k] = -100;
            return;
        end
        if (op == 0 || op == 8 || op == 9 || op == 10) begin
            srcs.push_back(rs); dst = rt;
        end else if (op >= 1 && op <= 7) begin
            srcs.push_back(rs); srcs.push_back(rt); dst = rd;
        end else if (op == 11) begin
            srcs.push_back(rs); srcs.push_back(rt);
        end else if (op == 12 || op == 13) begin
            srcs.push_back(rs);
        end
        e.cnt    = 16'(cnt[k]);
        e.halted = (mode[k] == 2);
        if (mode[k] == 2) begin
            e.stall = 1; e.bubble = 1;
        end else if (mode[k] == 1) begin
            e.stall = 1; e.bubble = 1;
            if (cyc + 1 >= halt_at[k]) mode[k] = 2;
        end else if (br) begin
            e.flush = 1; e.bubble = 1;
        end else if (!v) begin
            e.bubble = 1;
        end else begin
            depth = (k == 1) ? 2 : 3;
            foreach (srcs[i])
                if (srcs[i] != 0)
                    for (int d = 0; d < depth; d++)
                        if (hist[k][d] == srcs[i]) hz = 1;
            if (hz) begin
                e.stall = 1; e.bubble = 1;
                if (cnt[k] < cmax[k]) cnt[k]++;
            end else if (op == 15) begin
                // halt once the last real producer has left WB, and never before two drain cycles
                mode[k]    = 1;
                halt_at[k] = (cyc + 2 > last_dc[k] + 4) ? cyc + 2 : last_dc[k] + 4;
            end else begin
                issued = dst;
            end
        end
        hist[k][2] = hist[k][1];
        hist[k][1] = hist[k][0];
        hist[k][0] = issued;
        if (issued != 0) last_dc[k] = cyc;
    endtask

    task automatic drive(input bit rst, input bit v, input logic [15:0] ir, input bit br);
        obs_t e;
        reset       = rst;
        id_valid    = v;
        id_ir       = ir;
        ex_taken_br = br;
        model(1, rst, v, ir, br, e); q1.push_back(e);
        model(0, rst, v, ir, br, e); q0.push_back(e);
        cyc++;
    endtask

    task automatic tick();
        @(posedge clk1);
        #1;
    endtask

    task automatic step(input bit rst, input bit v, input logic [15:0] ir, input bit br);
        drive(rst, v, ir, br);
        tick();
    endtask

    always @(negedge clk1) begin
        obs_t e;
        if (q1.size() > 0) begin
            e = q1.pop_front();
            check("bypass_outputs", {12'b0, stall1, bubble1, flush1, halted1, cnt1}, {12'b0, e});
        end
        if (q0.size() > 0) begin
            e = q0.pop_front();
            check("nobypass_outputs", {12'b0, stall0, bubble0, flush0, halted0, 12'b0, cnt0},
                  {12'b0, e});
        end
    end

    logic [3:0] op4;
    logic [2:0] ra, rb, rc, imm;
    bit         r_rst, r_v, r_br;

    initial begin
        cmax[0] = 15;
        cmax[1] = 65535;
        reset = 1'b1; id_valid = 1'b0; id_ir = '0; ex_taken_br = 1'b0;
        tick();

        // reset state
        step(1, 0, 16'h0000, 0);
        drive(1, 1, 16'h12a0, 1);
        #2;
        check("reset_bypass", {28'b0, stall1, bubble1, flush1, halted1}, 32'd0);
        check("reset_nobypass", {28'b0, stall0, bubble0, flush0, halted0}, 32'd0);
        check("reset_cnt", {cnt1, 12'b0, cnt0}, 32'd0);
        tick();

        // dependent pair ADDI R1 ; ADD R4,R1,R2
        step(0, 1, 16'h004a, 0);
        drive(0, 1, 16'h12a0, 0);
        #2;
        check("pair_first_stall", {30'b0, stall1, stall0}, 32'd3);
        tick();
        repeat (3) step(0, 1, 16'h12a0, 0);
        #1;
        check("pair_cnt_bypass", {16'b0, cnt1}, 32'd2);
        check("pair_cnt_nobypass", {28'b0, cnt0}, 32'd3);

        // independent stream
        step(1, 0, 16'h0000, 0);
        step(0, 1, 16'h004a, 0);
        step(0, 1, 16'h0094, 0);
        step(0, 1, 16'h00d9, 0);
        step(0, 1, 16'h3ff8, 0);
        #1;
        check("indep_cnt", {cnt1, 12'b0, cnt0}, 32'd0);

        // R4 producer in MEM while branch resolves taken
        step(0, 1, 16'h0100, 0);
        step(0, 1, 16'h0094, 0);
        drive(0, 1, 16'h18e8, 1);
        #2;
        check("br_flush", {30'b0, flush1, flush0}, 32'd3);
        check("br_stall", {30'b0, stall1, stall0}, 32'd0);
        tick();
        #1;
        check("br_cnt_unchanged", {cnt1, 12'b0, cnt0}, 32'd0);

        // writes to R0 then reads of R0
        step(0, 1, 16'h0203, 0);
        step(0, 1, 16'h1018, 0);
        #1;
        check("r0_cnt", {cnt1, 12'b0, cnt0}, 32'd0);

        // HLT behind two ALU ops
        step(1, 0, 16'h0000, 0);
        step(0, 1, 16'h004a, 0);
        step(0, 1, 16'h0094, 0);
        step(0, 1, 16'hf000, 0);
        step(0, 1, 16'h12a0, 0);
        drive(0, 1, 16'h12a0, 0);
        #2;
        check("halt_not_early", {30'b0, halted1, halted0}, 32'd0);
        tick();
        drive(0, 1, 16'h12a0, 0);
        #2;
        check("halt_on_time", {30'b0, halted1, halted0}, 32'd3);
        tick();
        repeat (3) step(0, 1, 16'h12a0, 1);
        #1;
        check("halt_sticky", {30'b0, halted1, halted0}, 32'd3);

        // reset mid-drain
        step(1, 0, 16'h0000, 0);
        step(0, 1, 16'h004a, 0);
        step(0, 1, 16'hf000, 0);
        step(0, 1, 16'h0000, 0);
        drive(1, 1, 16'h0000, 0);
        #2;
        check("drain_reset_outputs", {28'b0, stall1, bubble1, halted1, halted0}, 32'd0);
        tick();
        drive(0, 1, 16'h0094, 0);
        #2;
        check("drain_reset_run", {27'b0, stall1, bubble1, halted1, stall0, halted0}, 32'd0);
        tick();

        // counter saturation on the 4-bit instance
        step(1, 0, 16'h0000, 0);
        repeat (6) begin
            step(0, 1, 16'h004a, 0);
            repeat (4) step(0, 1, 16'h12a0, 0);
        end
        #1;
        check("sat_cnt_bypass", {16'b0, cnt1}, 32'd12);
        check("sat_cnt_nobypass", {28'b0, cnt0}, 32'd15);

        // randomized traffic
        step(1, 0, 16'h0000, 0);
        for (int i = 0; i < 3000; i++) begin
            op4 = 4'($urandom_range(15));
            if (op4 == 4'hF && $urandom_range(3) != 0) op4 = 4'h1;
            ra    = 3'($urandom_range(4));
            rb    = 3'($urandom_range(4));
            rc    = 3'($urandom_range(4));
            imm   = 3'($urandom_range(7));
            r_v   = ($urandom_range(99) < 85);
            r_br  = ($urandom_range(99) < 8);
            r_rst = ($urandom_range(99) < 2) || (mode[1] == 2 && mode[0] == 2 &&
                                                 $urandom_range(3) == 0);
            step(r_rst, r_v, {op4, ra, rb, rc, imm}, r_br);
        end

        tick();
        tick();
        check("scoreboard_drained", q1.size() + q0.size(), 32'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
